// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one I2C write controller between NUM_REQ configuration requesters
// (e.g. HDMI transmitter setup and camera sensor setup). Each grant carries
// exactly one DATA_W-bit {dev_addr, reg_addr, data} frame to the controller.
// Requesters are served round-robin. A watchdog aborts a transaction whose
// controller never reports END, so a hung bus cannot starve the others.
//
// Ports
//   clk          I2C control clock; every requester is synchronous to it
//   reset        asynchronous, active-low reset
//   req          per-requester request level (ignored while busy)
//   req_data     frame of requester i at bits [i*DATA_W +: DATA_W]
//   gnt          one-hot grant, held for the whole transaction
//   done         one-cycle completion pulse to the granted requester
//   nack         result of the last transaction (1 = NACK or timeout),
//                valid from its done pulse until the next done pulse
//   timeout      one-cycle pulse, coincident with done, on watchdog abort
//   busy         high whenever the arbiter is not idle
//   ctrl_data    frame presented to the shared controller
//   ctrl_enable  controller start/hold level
//   ctrl_end     controller END; stays high until ctrl_enable drops
//   ctrl_nack    controller ACK flag (1 = slave did not acknowledge)
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 24,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      nack,
    output logic                      timeout,
    output logic                      busy,
    output logic [DATA_W-1:0]         ctrl_data,
    output logic                      ctrl_enable,
    input  logic                      ctrl_end,
    input  logic                      ctrl_nack
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so last_idx + offset never overflows before the wrap.
    localparam int SUM_W = IDX_W + 1;
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_END,
        S_RELEASE
    } state_t;

    // -----------------------------------------------------------------------
    // Registered state and outputs
    // -----------------------------------------------------------------------
    state_t               state_q,       state_d;
    logic [IDX_W-1:0]     last_idx_q,    last_idx_d;
    logic [IDX_W-1:0]     gidx_q,        gidx_d;
    logic [WD_W-1:0]      wd_q,          wd_d;
    logic [NUM_REQ-1:0]   gnt_q,         gnt_d;
    logic [NUM_REQ-1:0]   done_q,        done_d;
    logic                 nack_q,        nack_d;
    logic                 timeout_q,     timeout_d;
    logic                 busy_q,        busy_d;
    logic [DATA_W-1:0]    ctrl_data_q,   ctrl_data_d;
    logic                 ctrl_enable_q, ctrl_enable_d;

    // -----------------------------------------------------------------------
    // Per-requester frame view
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] frame_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frame
            assign frame_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin scan starting just after the last served requester.
    // Offsets are visited from farthest to nearest so the nearest set
    // request overwrites any farther candidate and wins.
    // -----------------------------------------------------------------------
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [SUM_W-1:0]  scan_sum;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            scan_sum = {1'b0, last_idx_q} + SUM_W'(off);
            if (scan_sum >= NUM_REQ_S) begin
                scan_sum = scan_sum - NUM_REQ_S;
            end
            if (req[scan_sum[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[IDX_W-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_idx_d    = last_idx_q;
        gidx_d        = gidx_q;
        wd_d          = wd_q;
        gnt_d         = gnt_q;
        done_d        = '0;          // pulses: low unless set below
        nack_d        = nack_q;
        timeout_d     = 1'b0;
        busy_d        = busy_q;
        ctrl_data_d   = ctrl_data_q;
        ctrl_enable_d = ctrl_enable_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    ctrl_data_d = frame_arr[win_idx];
                    gnt_d       = NUM_REQ'(1) << win_idx;
                    gidx_d      = win_idx;
                    busy_d      = 1'b1;
                    state_d     = S_START;
                end
            end

            S_START: begin
                ctrl_enable_d = 1'b1;
                wd_d          = '0;
                state_d       = S_WAIT_END;
            end

            S_WAIT_END: begin
                wd_d = wd_q + WD_W'(1);
                // END is checked first so a completion that lands on the
                // watchdog limit cycle still counts as a normal finish.
                if (ctrl_end) begin
                    nack_d        = ctrl_nack;
                    ctrl_enable_d = 1'b0;
                    done_d        = gnt_q;
                    state_d       = S_RELEASE;
                end else if (wd_q == WD_LIMIT) begin
                    nack_d        = 1'b1;
                    timeout_d     = 1'b1;
                    ctrl_enable_d = 1'b0;
                    done_d        = gnt_q;
                    state_d       = S_RELEASE;
                end
            end

            S_RELEASE: begin
                // Hold the grant until the controller has seen enable low
                // (END falls), so the next frame starts from a clean state.
                if (!ctrl_end) begin
                    gnt_d      = '0;
                    last_idx_d = gidx_q;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            last_idx_q    <= LAST_RST;
            gidx_q        <= '0;
            wd_q          <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            nack_q        <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            ctrl_data_q   <= '0;
            ctrl_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_idx_q    <= last_idx_d;
            gidx_q        <= gidx_d;
            wd_q          <= wd_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            nack_q        <= nack_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
            ctrl_data_q   <= ctrl_data_d;
            ctrl_enable_q <= ctrl_enable_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign nack        = nack_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;
    assign ctrl_data   = ctrl_data_q;
    assign ctrl_enable = ctrl_enable_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
//
// Rounds of simultaneous requests are issued; a round-robin reference model
// predicts the service order and pushes one expected completion per
// transaction into a scoreboard queue. A behavioural controller replies to
// each ctrl_enable according to a pre-planned latency / NACK / hang, and a
// monitor pops and compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

    localparam int N  = 3;
    localparam int DW = 24;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            nack;
    logic            timeout;
    logic            busy;
    logic [DW-1:0]   ctrl_data;
    logic            ctrl_enable;
    logic            ctrl_end;
    logic            ctrl_nack;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .NUM_REQ     (N),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .nack        (nack),
        .timeout     (timeout),
        .busy        (busy),
        .ctrl_data   (ctrl_data),
        .ctrl_enable (ctrl_enable),
        .ctrl_end    (ctrl_end),
        .ctrl_nack   (ctrl_nack)
    );

    // Controller behaviour for one transaction: END arrives so that it is
    // sampled lat clock edges after ctrl_enable rose, or never (hang).
    typedef struct {
        bit hang;
        int lat;
        bit nk;
    } plan_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] frame;
        bit            nk;
        bit            to;
    } exp_t;

    plan_t         plan_q[$];
    plan_t         dir_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] frames[N];
    int            m_last;
    int            tests     = 0;
    int            fails     = 0;
    int            done_seen = 0;
    bit            rst_test  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"},     gnt,         0);
        check({tag, "_done"},    done,        0);
        check({tag, "_nack"},    nack,        0);
        check({tag, "_timeout"}, timeout,     0);
        check({tag, "_busy"},    busy,        0);
        check({tag, "_enable"},  ctrl_enable, 0);
        check({tag, "_data"},    ctrl_data,   0);
    endtask

    // -----------------------------------------------------------------------
    // Behavioural controller
    // -----------------------------------------------------------------------
    initial begin
        ctrl_end  = 1'b0;
        ctrl_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (ctrl_enable === 1'b1) begin
                plan_t p;
                int    cyc;
                if (plan_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL plan_underflow: enable rose with no planned transaction");
                    p.hang = 1'b0;
                    p.lat  = 3;
                    p.nk   = 1'b0;
                end else begin
                    p = plan_q.pop_front();
                end
                cyc = 0;
                while (ctrl_enable === 1'b1 && cyc < TO + 40) begin
                    if (!p.hang && cyc == p.lat - 1) begin
                        ctrl_end  = 1'b1;
                        ctrl_nack = p.nk;
                    end
                    @(negedge clk);
                    cyc++;
                end
                // Enable must fall on the edge that saw END, or exactly
                // TO cycles after rising when the bus hangs.
                if (!rst_test) check("enable_width", cyc, p.hang ? TO : p.lat);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ctrl_end  = 1'b0;
                ctrl_nack = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    initial begin
        logic [N-1:0] done_prev;
        exp_t         e;
        done_prev = '0;
        forever begin
            @(negedge clk);
            check("gnt_onehot", ($countones(gnt) <= 1), 1);
            check("done_one_cycle", (done_prev != 0 && done != 0), 0);
            check("timeout_with_done", (timeout === 1'b1 && done == 0), 0);
            if (done != 0) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: done=%b with nothing expected", done);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] txn req=%0d frame=%06h nack=%0b timeout=%0b", e.idx, ctrl_data, nack, timeout);
                    check("done_idx",  done,      64'd1 << e.idx);
                    check("gnt_held",  gnt,       64'd1 << e.idx);
                    check("ctrl_data", ctrl_data, e.frame);
                    check("nack",      nack,      e.nk);
                    check("timeout",   timeout,   e.to);
                end
            end
            done_prev = done;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n  = 1'b1;
        m_last = N - 1;
        @(negedge clk);
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        int    r;
        r      = $urandom_range(0, 99);
        p.hang = (r < 15);
        p.lat  = (r < 25) ? TO : (r < 35) ? 1 : $urandom_range(2, TO - 1);
        p.nk   = ($urandom_range(0, 2) == 0);
        return p;
    endfunction

    // Raise all bits of mask at once; the model serves them round-robin
    // from the requester after the last one served.
    task automatic run_round(input logic [N-1:0] mask, input bit rnd, input bit chk_lat);
        logic [N-1:0] pend;
        int           first;
        int           n;
        first = -1;
        pend  = mask;
        while (pend != 0) begin
            int    pick;
            plan_t p;
            exp_t  e;
            pick = -1;
            for (int off = 1; off <= N; off++) begin
                int j;
                j = (m_last + off) % N;
                if (pick < 0 && pend[j]) pick = j;
            end
            pend[pick] = 1'b0;
            m_last     = pick;
            if (first < 0) first = pick;
            if (rnd || dir_q.size() == 0) p = rand_plan();
            else                          p = dir_q.pop_front();
            plan_q.push_back(p);
            e.idx   = pick;
            e.frame = frames[pick];
            e.nk    = p.hang | p.nk;
            e.to    = p.hang;
            exp_q.push_back(e);
        end

        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = frames[i];
        req = mask;

        if (chk_lat) begin
            @(posedge clk);
            #1;
            check("lat_enable_c1", ctrl_enable, 0);
            check("lat_gnt",       gnt,         64'd1 << first);
            check("lat_busy",      busy,        1);
            check("lat_data",      ctrl_data,   frames[first]);
            @(posedge clk);
            #1;
            check("lat_enable_c2", ctrl_enable, 1);
        end

        n = 0;
        while (req != 0 && n < 1500) begin
            @(negedge clk);
            req = req & ~done;      // drop request the cycle after done
            n++;
        end
        check("round_complete", req, 0);
        req = '0;
        wait_idle();
    endtask

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        plan_t pl;
        int    ds;
        logic [N-1:0] mask;

        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) frames[i] = '0;
        m_last   = N - 1;
        @(negedge clk);
        apply_reset();

        // Single requester, END after 10 cycles, ACK.
        frames[0] = 24'h729803;
        pl = '{hang: 1'b0, lat: 10, nk: 1'b0};
        dir_q.push_back(pl);
        run_round(3'b001, 1'b0, 1'b1);
        check("busy_after_release", busy, 0);

        // Two requesters from reset: grant order 0,1,0,1.
        apply_reset();
        frames[1] = 24'h420100;
        for (int k = 0; k < 4; k++) begin
            pl = '{hang: 1'b0, lat: 3 + k, nk: 1'b0};
            dir_q.push_back(pl);
        end
        run_round(3'b011, 1'b0, 1'b0);
        run_round(3'b011, 1'b0, 1'b0);

        // NACK then a clean transaction that clears it.
        frames[2] = 24'h5a0c11;
        pl = '{hang: 1'b0, lat: 4, nk: 1'b1};
        dir_q.push_back(pl);
        run_round(3'b100, 1'b0, 1'b0);
        pl = '{hang: 1'b0, lat: 6, nk: 1'b0};
        dir_q.push_back(pl);
        run_round(3'b100, 1'b0, 1'b0);

        // Hung bus on the first grant; the other requester is still served.
        pl = '{hang: 1'b1, lat: 0, nk: 1'b0};
        dir_q.push_back(pl);
        pl = '{hang: 1'b0, lat: 3, nk: 1'b0};
        dir_q.push_back(pl);
        run_round(3'b011, 1'b0, 1'b0);

        // END exactly on the watchdog limit cycle: normal completion.
        pl = '{hang: 1'b0, lat: TO, nk: 1'b1};
        dir_q.push_back(pl);
        run_round(3'b010, 1'b0, 1'b0);
        pl = '{hang: 1'b0, lat: TO, nk: 1'b0};
        dir_q.push_back(pl);
        run_round(3'b010, 1'b0, 1'b0);

        // Randomized rounds.
        for (int r = 0; r < 30; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) frames[i] = DW'($urandom);
            run_round(mask, 1'b1, 1'b0);
        end

        // Reset asserted in the middle of WAIT_END.
        frames[2] = DW'($urandom);
        req_data[2*DW +: DW] = frames[2];
        pl = '{hang: 1'b1, lat: 0, nk: 1'b0};
        plan_q.push_back(pl);
        req = 3'b100;
        ds  = 0;
        while (ctrl_enable !== 1'b1 && ds < 20) begin
            @(negedge clk);
            ds++;
        end
        check("rst_mid_enable_up", ctrl_enable, 1);
        repeat (5) @(negedge clk);
        rst_test = 1'b1;
        ds = done_seen;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        req = '0;
        repeat (3) @(negedge clk);
        check("rst_no_done", done_seen, ds);
        rst_n    = 1'b1;
        m_last   = N - 1;
        @(negedge clk);
        rst_test = 1'b0;

        // After reset requester 0 has first priority again.
        for (int i = 0; i < N; i++) frames[i] = DW'($urandom);
        run_round(3'b111, 1'b1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        check("plans_consumed",     plan_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C write controller (24-bit {dev_addr, reg_addr, data} frame, level enable, END/ACK status) between NUM_REQ configuration requesters, e.g. HDMI transmitter config and camera sensor config.
- Round-robin arbitration, one complete frame per grant.
- Adds a watchdog timeout so a hung bus cannot lock out the other requesters.
- Runs in the I2C control clock domain; all requesters must be synchronous to clk.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 24, frame width passed to the controller.
- TIMEOUT_CYC, 4096, max clk cycles in WAIT_END before abort; must be >= 2.

Ports:
- clk  in  1  I2C control clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  NUM_REQ*DATA_W  frame of requester i at bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- nack  out  1  result of the last transaction: 1 = NACK or timeout; valid from the done pulse until the next done.
- timeout  out  1  one-cycle pulse, coincident with done, on watchdog abort.
- busy  out  1  high in every state except IDLE.
- ctrl_data  out  DATA_W  frame to the shared controller.
- ctrl_enable  out  1  controller start/hold level.
- ctrl_end  in  1  controller END; stays high until enable drops.
- ctrl_nack  in  1  controller ACK flag; 1 = slave did not acknowledge.

Behaviour:
- Reset (async, active-low):
  - gnt=0, done=0, nack=0, timeout=0, busy=0, ctrl_enable=0, ctrl_data=0.
  - last_idx=NUM_REQ-1, so requester 0 has first priority; watchdog=0; state=IDLE.
- Asserting reset mid-transaction forces all of the above immediately. ctrl_enable drops, which aborts the controller. No done pulse is issued.
- FSM states: IDLE, START, WAIT_END, RELEASE.
- IDLE:
  - Scan req from index (last_idx+1) mod NUM_REQ upward with wrap-around; the first set bit wins.
  - On a win: latch ctrl_data <= that requester's frame, set gnt one-hot, busy=1, go to START.
  - With no req bit set, stay in IDLE.
- START: ctrl_enable<=1, watchdog<=0, go to WAIT_END. Latency from req sampled high in IDLE to ctrl_enable high is 2 cycles.
- WAIT_END:
  - Watchdog increments each cycle.
  - If ctrl_end=1: nack<=ctrl_nack, ctrl_enable<=0, done[g] pulse, go to RELEASE.
  - Else if watchdog==TIMEOUT_CYC-1: nack<=1, timeout pulse, ctrl_enable<=0, done[g] pulse, go to RELEASE.
  - If ctrl_end and the watchdog limit occur in the same cycle, ctrl_end wins: normal completion, no timeout pulse.
- RELEASE:
  - Wait for ctrl_end==0, so the controller has seen enable low.
  - Then gnt<=0, last_idx<=g, busy<=0, go to IDLE.
  - A timeout exit proceeds in the same way.
- Requester rules:
  - req and req_data are ignored while busy; a requester that drops req mid-transaction does not abort it.
  - ctrl_data is stable from START until RELEASE exits.
  - A requester must drop req in the cycle after done; if req is still high when IDLE is re-entered, that is a new request.
- Fairness:
  - Two simultaneous requests are served alternately.
  - A lone requester may be re-granted back-to-back, with a minimum of 1 IDLE cycle between transactions.
- done and timeout are registered outputs, never high for more than one cycle.

Test Plan:
- Reset then req=2'b01, frame 24'h729803, controller returns END after 10 cycles with ctrl_nack=0:
  - ctrl_enable rises 2 cycles after req.
  - ctrl_data=24'h729803, gnt=01.
  - done[0] pulses once, nack=0, busy returns to 0 after END falls.
- Both req high from reset (frames 24'h729803, 24'h420100):
  - Grant order is 0, 1, 0, 1 for 4 transactions.
  - gnt is never two-hot; ctrl_data matches the granted frame each time.
- Controller returns END with ctrl_nack=1: nack=1 at done[g]; timeout stays 0; the next successful transaction clears nack to 0.
- TIMEOUT_CYC=16, controller never asserts END:
  - ctrl_enable drops exactly 16 cycles after it rose.
  - timeout and done pulse together, nack=1.
  - The arbiter returns to IDLE and serves the other requester.
- ctrl_end asserted on the exact watchdog-limit cycle: normal completion, timeout=0, nack=ctrl_nack.
- Reset pulsed low in WAIT_END:
  - All outputs reach reset values asynchronously; no done pulse.
  - After release, the arbiter restarts with requester 0 priority.
